// File: rtl/wave_meter.sv
// Waveform analyser: finds rising mid-level crossings with hysteresis, measures
// the period between them in sys_clk cycles and reports per-period peak values.
module wave_meter #(
  parameter logic [7:0]  MID     = 8'd128,
  parameter logic [7:0]  HYST    = 8'd8,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  output logic [31:0] period_cnt,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic        meas_valid,
  output logic        signal_lost
);

  localparam logic [8:0] TH_HI = {1'b0, MID} + {1'b0, HYST};
  localparam logic [8:0] TH_LO = {1'b0, MID} - {1'b0, HYST};

  typedef enum logic [1:0] {SEEK_LOW, SEEK_RISE, WAIT_FALL, WAIT_RISE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [7:0]  run_max_reg, run_max_next;
  logic [7:0]  run_min_reg, run_min_next;
  logic [31:0] period_reg, period_next;
  logic [7:0]  vmax_reg, vmax_next;
  logic [7:0]  vmin_reg, vmin_next;
  logic        meas_valid_reg, meas_valid_next;
  logic        lost_reg, lost_next;

  logic low_ev, rise_ev, crossing, publish;

  assign low_ev   = adc_valid && ({1'b0, adc_data} < TH_LO);
  assign rise_ev  = adc_valid && ({1'b0, adc_data} >= TH_HI);
  // The first rising crossing only establishes the reference edge.
  assign crossing = rise_ev && (state_reg == SEEK_RISE || state_reg == WAIT_RISE);
  assign publish  = rise_ev && (state_reg == WAIT_RISE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= SEEK_LOW;
      cnt_reg        <= 32'd0;
      run_max_reg    <= 8'h00;
      run_min_reg    <= 8'hFF;
      period_reg     <= 32'd0;
      vmax_reg       <= 8'h00;
      vmin_reg       <= 8'hFF;
      meas_valid_reg <= 1'b0;
      lost_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      run_max_reg    <= run_max_next;
      run_min_reg    <= run_min_next;
      period_reg     <= period_next;
      vmax_reg       <= vmax_next;
      vmin_reg       <= vmin_next;
      meas_valid_reg <= meas_valid_next;
      lost_reg       <= lost_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + 32'd1;
    run_max_next    = run_max_reg;
    run_min_next    = run_min_reg;
    period_next     = period_reg;
    vmax_next       = vmax_reg;
    vmin_next       = vmin_reg;
    meas_valid_next = 1'b0;
    lost_next       = lost_reg;

    case (state_reg)
      SEEK_LOW:  if (low_ev)  state_next = SEEK_RISE;
      SEEK_RISE: if (rise_ev) state_next = WAIT_FALL;
      WAIT_FALL: if (low_ev)  state_next = WAIT_RISE;
      WAIT_RISE: if (rise_ev) state_next = WAIT_FALL;
      default:                state_next = SEEK_LOW;
    endcase

    // A crossing takes priority over a simultaneous timeout.
    if (crossing) begin
      cnt_next     = 32'd1;
      run_max_next = adc_data;
      run_min_next = adc_data;
    end else if (cnt_reg == TIMEOUT) begin
      lost_next    = 1'b1;
      state_next   = SEEK_LOW;
      cnt_next     = 32'd0;
      run_max_next = 8'h00;
      run_min_next = 8'hFF;
    end else if (adc_valid) begin
      if (adc_data > run_max_reg) run_max_next = adc_data;
      if (adc_data < run_min_reg) run_min_next = adc_data;
    end

    // Results use the pre-crossing counter and extremes, excluding this sample.
    if (publish) begin
      period_next     = cnt_reg;
      vmax_next       = run_max_reg;
      vmin_next       = run_min_reg;
      meas_valid_next = 1'b1;
      lost_next       = 1'b0;
    end
  end

  assign period_cnt  = period_reg;
  assign vmax        = vmax_reg;
  assign vmin        = vmin_reg;
  assign meas_valid  = meas_valid_reg;
  assign signal_lost = lost_reg;

endmodule

// File: tb/tb_wave_meter.sv
// Self-checking bench for wave_meter: table-driven square waves plus directed
// hysteresis, timeout, sine and mid-period reset sequences.
module tb_wave_meter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  adc_data = 8'd0;
  logic        adc_valid = 1'b0;
  logic [31:0] period_cnt;
  logic [7:0]  vmax, vmin;
  logic        meas_valid, signal_lost;

  int n_vec = 0;
  int n_err = 0;

  wave_meter #(.MID(8'd128), .HYST(8'd8), .TIMEOUT(32'd1000)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .period_cnt  (period_cnt),
    .vmax        (vmax),
    .vmin        (vmin),
    .meas_valid  (meas_valid),
    .signal_lost (signal_lost)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          half;
    int          vstep;
    int          periods;
    logic [31:0] period;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " period_cnt"}, period_cnt, 32'd0);
    chk({tag, " vmax"}, {24'd0, vmax}, 32'h00);
    chk({tag, " vmin"}, {24'd0, vmin}, 32'hFF);
    chk({tag, " meas_valid"}, {31'd0, meas_valid}, 32'd0);
    chk({tag, " signal_lost"}, {31'd0, signal_lost}, 32'd0);
  endtask

  task automatic do_reset();
    adc_valid = 1'b0;
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #5;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  // Starts from SEEK_LOW: low half first, so the first publish lands on valid
  // sample 3*half and every 2*half samples after that.
  task automatic run_square(input logic [7:0] lo, input logic [7:0] hi, input int half,
                            input int vstep, input int periods, input logic [31:0] ep,
                            input logic [7:0] emax, input logic [7:0] emin,
                            input logic lost0, input string tag);
    logic       exp_lost;
    logic [7:0] d;
    logic       pub;
    exp_lost = lost0;
    for (int s = 0; s < 2 * half * periods; s++) begin
      d   = (((s / half) % 2) != 0) ? hi : lo;
      pub = (s >= 3 * half) && (((s - half) % (2 * half)) == 0);
      step(1'b1, d);
      if (pub) exp_lost = 1'b0;
      chk({tag, " meas_valid"}, {31'd0, meas_valid}, {31'd0, pub});
      chk({tag, " signal_lost"}, {31'd0, signal_lost}, {31'd0, exp_lost});
      if (pub) begin
        chk({tag, " period_cnt"}, period_cnt, ep);
        chk({tag, " vmax"}, {24'd0, vmax}, {24'd0, emax});
        chk({tag, " vmin"}, {24'd0, vmin}, {24'd0, emin});
      end
      for (int k = 1; k < vstep; k++) begin
        step(1'b0, ~d);
        chk({tag, " gated meas_valid"}, {31'd0, meas_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    int   pubs;
    int   sv;
    real  x;

    tbl[0] = '{lo: 8'd0,   hi: 8'd255, half: 50, vstep: 1, periods: 4, period: 32'd100, vmax: 8'd255, vmin: 8'd0};
    tbl[1] = '{lo: 8'd0,   hi: 8'd255, half: 20, vstep: 2, periods: 4, period: 32'd80,  vmax: 8'd255, vmin: 8'd0};
    tbl[2] = '{lo: 8'd119, hi: 8'd137, half: 10, vstep: 1, periods: 5, period: 32'd20,  vmax: 8'd137, vmin: 8'd119};
    tbl[3] = '{lo: 8'd10,  hi: 8'd200, half: 30, vstep: 1, periods: 4, period: 32'd60,  vmax: 8'd200, vmin: 8'd10};
    tbl[4] = '{lo: 8'd100, hi: 8'd160, half: 15, vstep: 3, periods: 4, period: 32'd90,  vmax: 8'd160, vmin: 8'd100};

    // Reset state, observed while reset is still held.
    #25;
    chk_reset_vals("reset");
    sys_rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_square(tbl[i].lo, tbl[i].hi, tbl[i].half, tbl[i].vstep, tbl[i].periods,
                 tbl[i].period, tbl[i].vmax, tbl[i].vmin, 1'b0, $sformatf("vec%0d", i));
    end

    // Hysteresis: a glitch band inside +/-(HYST-1) never crosses; the state
    // must still be SEEK_RISE, so reference+low+rise publishes a 2-cycle period.
    do_reset();
    step(1'b1, 8'd0);
    pubs = 0;
    for (int k = 0; k < 900; k++) begin
      step(1'b1, (k % 2 == 0) ? 8'd123 : 8'd133);
      if (meas_valid) pubs++;
    end
    chk("hyst publishes", pubs, 32'd0);
    chk("hyst signal_lost", {31'd0, signal_lost}, 32'd0);
    step(1'b1, 8'd255);
    chk("hyst ref meas_valid", {31'd0, meas_valid}, 32'd0);
    step(1'b1, 8'd0);
    chk("hyst low meas_valid", {31'd0, meas_valid}, 32'd0);
    step(1'b1, 8'd255);
    chk("hyst cross meas_valid", {31'd0, meas_valid}, 32'd1);
    chk("hyst period_cnt", period_cnt, 32'd2);
    chk("hyst vmax", {24'd0, vmax}, 32'd255);
    chk("hyst vmin", {24'd0, vmin}, 32'd0);

    // Sine at a 200-cycle period: period within +/-1, full-scale peaks.
    do_reset();
    pubs = 0;
    for (int n = 0; n < 1100; n++) begin
      x  = 127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * n / 200.0);
      sv = int'(x);
      if (sv < 0) sv = 0;
      if (sv > 255) sv = 255;
      step(1'b1, sv[7:0]);
      if (signal_lost) chk("sine signal_lost", {31'd0, signal_lost}, 32'd0);
      if (meas_valid) begin
        pubs++;
        chk("sine period range", {31'd0, (period_cnt >= 32'd199 && period_cnt <= 32'd201)}, 32'd1);
        chk("sine vmax>=250", {31'd0, (vmax >= 8'd250)}, 32'd1);
        chk("sine vmin<=5", {31'd0, (vmin <= 8'd5)}, 32'd1);
      end
    end
    chk("sine publish count", pubs, 32'd4);

    // Timeout: last crossing at sample 250, run ends 49 edges later. The loss
    // flag rises on the TIMEOUT-th edge after the crossing edge.
    do_reset();
    run_square(8'd0, 8'd255, 50, 1, 3, 32'd100, 8'd255, 8'd0, 1'b0, "pre_to");
    for (int k = 50; k <= 1000; k++) begin
      step(1'b1, 8'd128);
      if (k >= 999) chk($sformatf("timeout lost@%0d", k), {31'd0, signal_lost}, {31'd0, (k == 1000)});
    end
    chk("timeout frozen period", period_cnt, 32'd100);
    chk("timeout frozen vmax", {24'd0, vmax}, 32'd255);
    chk("timeout frozen vmin", {24'd0, vmin}, 32'd0);
    chk("timeout meas_valid", {31'd0, meas_valid}, 32'd0);
    run_square(8'd0, 8'd255, 50, 1, 2, 32'd100, 8'd255, 8'd0, 1'b1, "restart");

    // Asynchronous reset in WAIT_FALL, then two crossings needed again.
    do_reset();
    run_square(8'd0, 8'd255, 50, 1, 2, 32'd100, 8'd255, 8'd0, 1'b0, "pre_rst");
    step(1'b1, 8'd255);
    step(1'b1, 8'd255);
    #4;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge sys_clk);
    #5;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    run_square(8'd0, 8'd255, 50, 1, 3, 32'd100, 8'd255, 8'd0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
